// File: rtl/bayer_quad_assembler.sv
// RGGB Bayer pixel stream to 2x2 quad {R, G1, G2, B} assembler with a one-row line memory.
// Optional transferred-quad counter output enabled by defining QUAD_COUNT_EN.
module bayer_quad_assembler #(
   parameter int IMG_WIDTH = 640,
   parameter int COL_W     = $clog2(IMG_WIDTH)
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        frame_sync,
   input  logic [7:0]  pix_in,
   input  logic        pix_valid,
   output logic        pix_ready,
   output logic [31:0] quad_out,
   output logic        quad_valid,
   input  logic        quad_ready,
   output logic        quad_last
`ifdef QUAD_COUNT_EN
   ,
   output logic [19:0] quad_count
`endif
);

   typedef enum logic {EVEN_ROW = 1'b0, ODD_ROW = 1'b1} row_e;

   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

   logic [7:0]       line_mem [IMG_WIDTH];
   row_e             state_q;
   logic [COL_W-1:0] col_q;
   logic [7:0]       g2_hold_q;
   logic [31:0]      quad_q;
   logic             quad_valid_q;
   logic             quad_last_q;

   logic             accept;
   logic             take;
   logic             col_last;
   logic [COL_W-1:0] col_prev;
   logic [7:0]       r_rd;
   logic [7:0]       g1_rd;

   assign pix_ready  = n_rst & (~quad_valid_q | quad_ready);
   assign accept     = pix_valid & pix_ready;
   assign take       = quad_valid_q & quad_ready;
   assign col_last   = (col_q == LAST_COL);
   // Only meaningful on odd columns, where col-1 is the R position of the pair.
   assign col_prev   = col_q - 1'b1;
   assign r_rd       = line_mem[col_prev];
   assign g1_rd      = line_mem[col_q];

   assign quad_out   = quad_q;
   assign quad_valid = quad_valid_q;
   assign quad_last  = quad_last_q;

   always_ff @(posedge clk) begin
      if (accept && (frame_sync || state_q == EVEN_ROW))
         line_mem[frame_sync ? '0 : col_q] <= pix_in;
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q      <= EVEN_ROW;
         col_q        <= '0;
         g2_hold_q    <= '0;
         quad_q       <= '0;
         quad_valid_q <= 1'b0;
         quad_last_q  <= 1'b0;
      end else begin
         if (take)
            quad_valid_q <= 1'b0;
         if (frame_sync) begin
            // A pixel arriving with frame_sync is column 0 of the new frame's even row.
            state_q   <= EVEN_ROW;
            g2_hold_q <= '0;
            col_q     <= accept ? COL_W'(1) : '0;
         end else if (accept) begin
            if (col_last) begin
               col_q   <= '0;
               state_q <= (state_q == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
            end else begin
               col_q <= col_q + 1'b1;
            end
            if (state_q == ODD_ROW) begin
               if (!col_q[0]) begin
                  g2_hold_q <= pix_in;
               end else begin
                  quad_q       <= {r_rd, g1_rd, g2_hold_q, pix_in};
                  quad_valid_q <= 1'b1;
                  quad_last_q  <= col_last;
               end
            end
         end
      end
   end

`ifdef QUAD_COUNT_EN
   logic [19:0] count_q;

   assign quad_count = count_q;

   always_ff @(posedge clk) begin
      if (!n_rst)
         count_q <= '0;
      else if (frame_sync)
         count_q <= take ? 20'd1 : 20'd0;
      else if (take && count_q != '1)
         count_q <= count_q + 1'b1;
   end
`endif

endmodule

// File: doc/bayer_quad_assembler.md
Name: bayer_quad_assembler

Overview:
- Upstream feeder for the filter top level.
- Accepts a raw 8-bit RGGB Bayer pixel stream in raster order and buffers the even row in a line memory.
- Pairs each even row with the following odd row and emits one 32-bit 2x2 quad {R, G1, G2, B} per two odd-row pixels.
- The quad output drives the filter stage's 32-bit `in` input.

Parameters:
- IMG_WIDTH, 640: pixels per row; must be even and >= 2.
- COL_W, $clog2(IMG_WIDTH): column counter width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  reset, synchronous, active-low.
- frame_sync  input  1  one-cycle pulse marking start of frame.
- pix_in  input  8  raw Bayer pixel.
- pix_valid  input  1  pix_in valid.
- pix_ready  output  1  block accepts pix_in this cycle.
- quad_out  output  32  [31:24]=R, [23:16]=G1, [15:8]=G2, [7:0]=B.
- quad_valid  output  1  quad_out valid.
- quad_ready  input  1  downstream accepts quad.
- quad_last  output  1  qualifies quad_out; last quad of a row pair.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous and active-low on n_rst.
  - Reset values: quad_out=0, quad_valid=0, quad_last=0, col=0, row_odd=0, g2_hold=0.
  - pix_ready=0 during reset, 1 the first cycle after.
  - Line memory contents are not reset.
- Handshakes:
  - Pixel accepted when pix_valid && pix_ready.
  - Quad transferred when quad_valid && quad_ready.
  - pix_ready = ~quad_valid | quad_ready, registered-free combinational. Input stalls only while the output register holds an untaken quad.
- Position tracking:
  - col increments per accepted pixel.
  - At col==IMG_WIDTH-1, col wraps to 0 and row_odd toggles.
- Even row (row_odd=0):
  - Accepted pixel is written to line_mem[col].
  - R at even col, G1 at odd col.
  - No output.
- Odd row (row_odd=1):
  - Even col: pixel stored in g2_hold.
  - Odd col: the quad completes. Next cycle quad_out = {line_mem[col-1], line_mem[col], g2_hold, pix_in} and quad_valid=1.
  - quad_last=1 iff that col==IMG_WIDTH-1.
- Latency: 1 cycle from the accepting edge of the completing B pixel to quad_valid.
- Output hold: quad_out, quad_valid and quad_last are held stable until taken.
- Simultaneous transfer: a new quad may load in the same cycle the old one is taken (full throughput, 1 quad per 2 odd-row pixels).
- Control is a 2-state FSM (EVEN_ROW, ODD_ROW) plus the column counter.
- frame_sync:
  - Forces col=0, row_odd=0, g2_hold=0.
  - Any partial row is discarded.
  - A pending quad in the output register is not cleared.
- frame_sync in the same cycle as an accepted pixel: the pixel is treated as col 0 of an even row of the new frame.
- Line memory read: uses the write-port-free odd row, so there are no read/write collisions.
- Mid-operation reset: all state returns to reset values on the next edge, and any pending quad is dropped.

Optional Feature:
- Macro: QUAD_COUNT_EN.
- When defined:
  - Adds output port quad_count [19:0].
  - Counts quads transferred (quad_valid && quad_ready) since the last frame_sync or reset, saturating at 20'hFFFFF.
  - frame_sync clears it to 0 unless a transfer occurs the same cycle, in which case it becomes 1.
- When undefined: the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- IMG_WIDTH=4, quad_ready=1; rows 10,11,12,13 then 20,21,22,23 -> quads 32'h0A0B1415 (quad_last=0) then 32'h0C0D1617 (quad_last=1), each 1 cycle after its B pixel.
- Same stream with quad_ready=0 after the first quad -> quad_out is held at 0C0D1617, pix_ready=0 until quad_ready=1, and no pixel is lost.
- frame_sync pulsed after 3 pixels of the odd row, then a fresh 8-pixel frame -> only the new frame's two quads are emitted; the partial row produces nothing.
- Reset (n_rst=0, 1 cycle) while quad_valid=1 -> next cycle quad_valid=0, quad_out=0, col=0, and the next pixel lands in line_mem[0].
- pix_valid toggling 1/0 every cycle with quad_ready toggling 0/1 -> output quad sequence identical to the continuous-stream case.
- QUAD_COUNT_EN, IMG_WIDTH=4, 2 frames of 4 rows each -> quad_count reads 4 before the second frame_sync, 0 after it, and 4 at the end.
